// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Package  : structures
// Purpose  : Shared MEM-stage request types plus the data-memory responder
//            state, latched-request record and alignment helper.
// Revision : 1.0 - initial release
// ============================================================================
package structures;

  localparam int DATA_W = 64;

  typedef enum logic [1:0] {
    NO_LOAD    = 2'd0,
    LOAD_BYTE  = 2'd1,
    LOAD_WORD  = 2'd2,
    LOAD_DWORD = 2'd3
  } mem_load_type_t;

  typedef enum logic [1:0] {
    NO_STORE    = 2'd0,
    STORE_BYTE  = 2'd1,
    STORE_WORD  = 2'd2,
    STORE_DWORD = 2'd3
  } mem_store_type_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } dmem_state_t;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    mem_load_type_t    load_type;
    mem_store_type_t   store_type;
    logic              is_signed;
    logic [DATA_W-1:0] wdata;
  } dmem_req_t;

  // A store overrides any load in the same request, so alignment is judged
  // on the store size whenever a store is present.
  function automatic logic is_misaligned(input logic [2:0]      addr_lo,
                                         input mem_load_type_t  load_type,
                                         input mem_store_type_t store_type);
    logic mis;
    mis = 1'b0;
    if (store_type != NO_STORE) begin
      case (store_type)
        STORE_WORD:  mis = (addr_lo[1:0] != 2'b00);
        STORE_DWORD: mis = (addr_lo != 3'b000);
        default:     mis = 1'b0;
      endcase
    end else begin
      case (load_type)
        LOAD_WORD:  mis = (addr_lo[1:0] != 2'b00);
        LOAD_DWORD: mis = (addr_lo != 3'b000);
        default:    mis = 1'b0;
      endcase
    end
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_sram.sv
`default_nettype none
// ============================================================================
// Module   : dmem_sram
// Purpose  : 64-bit-wide single-port synchronous SRAM, one-cycle read,
//            full-entry write, contents not reset.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_sram #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic                  we,
  input  logic [63:0]           wdata,
  output logic [63:0]           rdata
);

  logic [63:0] mem [0:(2**DEPTH_LOG2)-1];

  // Registered read of the addressed entry; write replaces the whole entry.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Purpose  : Far-end responder for MEM-stage loads/stores on a 64-bit SRAM.
//            Sub-dword stores use read-modify-write; loads are extended.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder
  import structures::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [63:0]     req_addr,
  input  mem_load_type_t  req_load_type,
  input  mem_store_type_t req_store_type,
  input  logic            req_signed,
  input  logic [63:0]     req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [63:0]     resp_rdata,
  output logic            resp_misaligned
);

  dmem_state_t           state, next_state;
  dmem_req_t             req_q;
  logic [63:0]           rdata_q;
  logic                  mis_q;
  logic [63:0]           wr_data_q;

  logic [DEPTH_LOG2-1:0] sram_addr;
  logic                  sram_we;
  logic [63:0]           sram_rdata;
  logic                  req_mis;
  logic                  req_nop;
  logic [5:0]            byte_shift;
  logic [63:0]           shifted;
  logic [31:0]           word_sel;
  logic [63:0]           merged;
  logic [63:0]           extended;
  logic                  unused_addr_bits;

  assign req_mis  = is_misaligned(req_addr[2:0], req_load_type, req_store_type);
  assign req_nop  = (req_load_type == NO_LOAD) && (req_store_type == NO_STORE);

  // The read is issued on the accept edge so data is ready during READ.
  assign sram_addr = (state == IDLE) ? req_addr[DEPTH_LOG2+2:3]
                                     : req_q.addr[DEPTH_LOG2+2:3];
  assign sram_we   = (state == WRITE) && !reset;

  assign unused_addr_bits = ^req_q.addr[63:DEPTH_LOG2+3];

  dmem_sram #(.DEPTH_LOG2(DEPTH_LOG2)) u_sram (
    .clock (clock),
    .addr  (sram_addr),
    .we    (sram_we),
    .wdata (wr_data_q),
    .rdata (sram_rdata)
  );

  // Lane selection, store merge and load extension on the SRAM read data.
  always_comb begin
    byte_shift = {req_q.addr[2:0], 3'b000};
    shifted    = sram_rdata >> byte_shift;
    word_sel   = req_q.addr[2] ? sram_rdata[63:32] : sram_rdata[31:0];

    merged = sram_rdata;
    case (req_q.store_type)
      STORE_BYTE: merged[byte_shift +: 8] = req_q.wdata[7:0];
      STORE_WORD: begin
        if (req_q.addr[2]) merged[63:32] = req_q.wdata[31:0];
        else               merged[31:0]  = req_q.wdata[31:0];
      end
      default:    merged = req_q.wdata;
    endcase

    extended = sram_rdata;
    case (req_q.load_type)
      LOAD_BYTE: extended = {{56{req_q.is_signed & shifted[7]}}, shifted[7:0]};
      LOAD_WORD: extended = {{32{req_q.is_signed & word_sel[31]}}, word_sel};
      default:   extended = sram_rdata;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state      = state;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    resp_rdata      = rdata_q;
    resp_misaligned = mis_q;
    case (state)
      IDLE: begin
        req_ready = !reset;
        if (req_valid) begin
          if (req_mis || req_nop)              next_state = RESP;
          else if (req_store_type == STORE_DWORD) next_state = WRITE;
          else                                 next_state = READ;
        end
      end
      READ: begin
        next_state = (req_q.store_type != NO_STORE) ? WRITE : RESP;
      end
      WRITE: begin
        next_state = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request latch and response/write-data capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_q     <= '0;
      rdata_q   <= '0;
      mis_q     <= 1'b0;
      wr_data_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            req_q.addr       <= req_addr;
            req_q.load_type  <= req_load_type;
            req_q.store_type <= req_store_type;
            req_q.is_signed  <= req_signed;
            req_q.wdata      <= req_wdata;
            rdata_q          <= '0;
            mis_q            <= req_mis;
            wr_data_q        <= req_wdata;
          end
        end
        READ: begin
          if (req_q.store_type != NO_STORE) wr_data_q <= merged;
          else                              rdata_q   <= extended;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Purpose  : Directed, table-driven bench for data_mem_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;
  import structures::*;

  logic            clock = 1'b0;
  logic            reset;
  logic            req_valid;
  logic            req_ready;
  logic [63:0]     req_addr;
  mem_load_type_t  req_load_type;
  mem_store_type_t req_store_type;
  logic            req_signed;
  logic [63:0]     req_wdata;
  logic            resp_valid;
  logic            resp_ready;
  logic [63:0]     resp_rdata;
  logic            resp_misaligned;

  int tests  = 0;
  int failed = 0;

  data_mem_responder #(.DEPTH_LOG2(10)) dut (
    .clock           (clock),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_addr        (req_addr),
    .req_load_type   (req_load_type),
    .req_store_type  (req_store_type),
    .req_signed      (req_signed),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_ready      (resp_ready),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned)
  );

  always #5 clock = ~clock;

  typedef struct {
    string           name;
    mem_load_type_t  lt;
    mem_store_type_t st;
    logic            sgn;
    logic [63:0]     addr;
    logic [63:0]     wdata;
    logic [63:0]     exp_rdata;
    logic            exp_mis;
    int              exp_lat;
    int              hold;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input string name, input mem_load_type_t lt,
                              input mem_store_type_t st, input logic sgn,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [63:0] exp_rdata, input logic exp_mis,
                              input int exp_lat, input int hold);
    vec_t v;
    v.name = name; v.lt = lt; v.st = st; v.sgn = sgn; v.addr = addr;
    v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_mis = exp_mis;
    v.exp_lat = exp_lat; v.hold = hold;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input vec_t v);
    req_valid      = 1'b1;
    req_addr       = v.addr;
    req_load_type  = v.lt;
    req_store_type = v.st;
    req_signed     = v.sgn;
    req_wdata      = v.wdata;
  endtask

  task automatic run_txn(input vec_t v);
    int lat;
    logic [63:0] held_rdata;
    logic        held_mis;
    @(negedge clock);
    resp_ready = 1'b0;
    drive_req(v);
    chk({v.name, ".req_ready"}, {63'd0, req_ready}, 64'd1);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 10) begin
      @(posedge clock);
      #1;
      lat++;
    end
    chk({v.name, ".resp_valid"}, {63'd0, resp_valid}, 64'd1);
    chk({v.name, ".latency"}, 64'(lat), 64'(v.exp_lat));
    chk({v.name, ".rdata"}, resp_rdata, v.exp_rdata);
    chk({v.name, ".misaligned"}, {63'd0, resp_misaligned}, {63'd0, v.exp_mis});
    held_rdata = resp_rdata;
    held_mis   = resp_misaligned;
    for (int h = 0; h < v.hold; h++) begin
      @(posedge clock);
      #1;
      chk({v.name, ".hold_valid"}, {63'd0, resp_valid}, 64'd1);
      chk({v.name, ".hold_rdata"}, resp_rdata, held_rdata);
      chk({v.name, ".hold_mis"}, {63'd0, resp_misaligned}, {63'd0, held_mis});
      chk({v.name, ".hold_req_ready"}, {63'd0, req_ready}, 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    chk({v.name, ".after_handshake"}, {63'd0, resp_valid}, 64'd0);
  endtask

  initial begin
    vec_t rv;
    reset          = 1'b1;
    req_valid      = 1'b0;
    req_addr       = '0;
    req_load_type  = NO_LOAD;
    req_store_type = NO_STORE;
    req_signed     = 1'b0;
    req_wdata      = '0;
    resp_ready     = 1'b0;

    vq.push_back(mk("sd_40",      NO_LOAD,    STORE_DWORD, 0, 64'h40, 64'h1122334455667788, 64'h0, 0, 2, 0));
    vq.push_back(mk("ld_40_a",    LOAD_DWORD, NO_STORE,    0, 64'h40, 64'h0, 64'h1122334455667788, 0, 2, 0));
    vq.push_back(mk("sb_43",      NO_LOAD,    STORE_BYTE,  0, 64'h43, 64'hAB, 64'h0, 0, 3, 0));
    vq.push_back(mk("ld_40_b",    LOAD_DWORD, NO_STORE,    0, 64'h40, 64'h0, 64'h11223344AB667788, 0, 2, 0));
    vq.push_back(mk("lb_43_s",    LOAD_BYTE,  NO_STORE,    1, 64'h43, 64'h0, 64'hFFFFFFFFFFFFFFAB, 0, 2, 0));
    vq.push_back(mk("lb_43_u",    LOAD_BYTE,  NO_STORE,    0, 64'h43, 64'h0, 64'h00000000000000AB, 0, 2, 0));
    vq.push_back(mk("sw_44",      NO_LOAD,    STORE_WORD,  0, 64'h44, 64'h80000000, 64'h0, 0, 3, 0));
    vq.push_back(mk("lw_44_s",    LOAD_WORD,  NO_STORE,    1, 64'h44, 64'h0, 64'hFFFFFFFF80000000, 0, 2, 0));
    vq.push_back(mk("ld_40_hold", LOAD_DWORD, NO_STORE,    0, 64'h40, 64'h0, 64'h80000000AB667788, 0, 2, 3));
    vq.push_back(mk("lw_42_mis",  LOAD_WORD,  NO_STORE,    0, 64'h42, 64'h0, 64'h0, 1, 1, 0));
    vq.push_back(mk("ld_40_c",    LOAD_DWORD, NO_STORE,    0, 64'h40, 64'h0, 64'h80000000AB667788, 0, 2, 0));
    vq.push_back(mk("nop",        NO_LOAD,    NO_STORE,    0, 64'h40, 64'h0, 64'h0, 0, 1, 0));
    vq.push_back(mk("sd_45_mis",  NO_LOAD,    STORE_DWORD, 0, 64'h45, 64'hFFFFFFFFFFFFFFFF, 64'h0, 1, 1, 0));
    vq.push_back(mk("sw_46_mis",  NO_LOAD,    STORE_WORD,  0, 64'h46, 64'hFFFFFFFF, 64'h0, 1, 1, 0));
    vq.push_back(mk("sb_ld_40",   LOAD_DWORD, STORE_BYTE,  0, 64'h40, 64'h5A, 64'h0, 0, 3, 0));
    vq.push_back(mk("ld_40_d",    LOAD_DWORD, NO_STORE,    0, 64'h40, 64'h0, 64'h80000000AB66775A, 0, 2, 0));
    vq.push_back(mk("lw_44_u",    LOAD_WORD,  NO_STORE,    0, 64'h44, 64'h0, 64'h0000000080000000, 0, 2, 0));
    vq.push_back(mk("sd_48",      NO_LOAD,    STORE_DWORD, 0, 64'h48, 64'hDEADBEEF00C0FFEE, 64'h0, 0, 2, 0));
    vq.push_back(mk("ld_wrap",    LOAD_DWORD, NO_STORE,    0, 64'h2048, 64'h0, 64'hDEADBEEF00C0FFEE, 0, 2, 0));
    vq.push_back(mk("lb_4f_u",    LOAD_BYTE,  NO_STORE,    0, 64'h4F, 64'h0, 64'h00000000000000DE, 0, 2, 0));

    // Reset state, both during reset and on the first cycle after release.
    repeat (2) @(posedge clock);
    #1;
    chk("rst.req_ready",  {63'd0, req_ready}, 64'd0);
    chk("rst.resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("rst.rdata",      resp_rdata, 64'd0);
    chk("rst.misaligned", {63'd0, resp_misaligned}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    #1;
    chk("post_rst.resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("post_rst.rdata",      resp_rdata, 64'd0);
    chk("post_rst.req_ready",  {63'd0, req_ready}, 64'd1);

    foreach (vq[i]) run_txn(vq[i]);

    // Reset during the WRITE cycle must drop the store and the response.
    @(negedge clock);
    rv = mk("sd_48_abort", NO_LOAD, STORE_DWORD, 0, 64'h48, 64'hFFFFFFFFFFFFFFFF, 64'h0, 0, 2, 0);
    drive_req(rv);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    chk("abort.in_write_no_resp", {63'd0, resp_valid}, 64'd0);
    chk("abort.in_write_not_ready", {63'd0, req_ready}, 64'd0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("abort.rst_resp_valid", {63'd0, resp_valid}, 64'd0);
    chk("abort.rst_req_ready",  {63'd0, req_ready}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      chk("abort.no_late_resp", {63'd0, resp_valid}, 64'd0);
    end
    chk("abort.rdata_clear", resp_rdata, 64'd0);
    run_txn(mk("ld_48_old", LOAD_DWORD, NO_STORE, 0, 64'h48, 64'h0, 64'hDEADBEEF00C0FFEE, 0, 2, 0));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
